// File: rtl/obi_tcdm_bridge_pkg.sv
// obi_tcdm_bridge_pkg: shared types and helpers for the OBI-to-TCDM bridge.
// Holds the occupancy state encoding and the counter-width helper used to
// size the outstanding and drop counters.
package obi_tcdm_bridge_pkg;

    // Largest supported number of granted-but-unanswered transactions.
    localparam int MAX_OUTSTANDING_LIMIT = 15;

    // Occupancy of the outstanding window, decoded from the counter.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } bridge_state_e;

    // Bits needed to hold a count from 0 up to and including max_outstanding.
    function automatic int cnt_w(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage : obi_tcdm_bridge_pkg

// File: rtl/obi_tcdm_bridge_wdt.sv
// obi_tcdm_bridge_wdt: response watchdog for the OBI-to-TCDM bridge.
// Counts cycles while start_i is high, restarts on clear_i, and raises
// fire_o for one cycle when TIMEOUT_CYCLES cycles have elapsed without a
// clear. Only instantiated when OBI_TCDM_BRIDGE_TIMEOUT_EN is defined.
module obi_tcdm_bridge_wdt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic clear_i,
    output logic fire_o
);

    localparam int            TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] ONE   = TW'(1);

    logic [TW-1:0] r_count;
    logic          w_expired;

    // The first counted cycle sees r_count == 0, so the limit is reached on
    // the TIMEOUT_CYCLES-th cycle of waiting.
    assign w_expired = (r_count == LIMIT);
    assign fire_o    = start_i & ~clear_i & w_expired;

    // Cycle counter: runs while armed, restarts on a response, when idle,
    // and after firing so the next outstanding transaction gets a full window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: flops are written with <= so every register samples the
        // pre-edge value of its inputs regardless of statement order.
        if (rst_i) begin
            r_count <= '0;
        end else if (!start_i || clear_i || w_expired) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + ONE;
        end
    end

endmodule : obi_tcdm_bridge_wdt

// File: rtl/obi_tcdm_bridge.sv
// obi_tcdm_bridge: core-side OBI request/response port to a PULP
// XBAR_TCDM-style master port with a configurable number of outstanding
// transactions. Request and response paths are combinational; only the
// outstanding count (and, optionally, the watchdog and drop count) is stored.
// Define OBI_TCDM_BRIDGE_TIMEOUT_EN to add a response watchdog that answers
// the core with an error instead of hanging, and swallows the late response.
module obi_tcdm_bridge
    import obi_tcdm_bridge_pkg::*;
#(
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int MAX_OUTSTANDING = 1,
    parameter  int TIMEOUT_CYCLES  = 1024,
    localparam int BE_WIDTH        = DATA_WIDTH / 8,
    localparam int CNT_W           = cnt_w(MAX_OUTSTANDING)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  obi_req_i,
    output logic                  obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0] obi_addr_i,
    input  logic                  obi_we_i,
    input  logic [BE_WIDTH-1:0]   obi_be_i,
    input  logic [DATA_WIDTH-1:0] obi_wdata_i,
    output logic                  obi_rvalid_o,
    output logic [DATA_WIDTH-1:0] obi_rdata_o,
    output logic                  obi_err_o,

    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0] tcdm_add_o,
    output logic                  tcdm_wen_o,
    output logic [BE_WIDTH-1:0]   tcdm_be_o,
    output logic [DATA_WIDTH-1:0] tcdm_wdata_o,
    input  logic                  tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0] tcdm_r_rdata_i,
    input  logic                  tcdm_r_opc_i,

    output logic [CNT_W-1:0]      outstanding_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Elaboration-time guard against unsupported parameter combinations.
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MAX_OUTSTANDING_LIMIT ||
        TIMEOUT_CYCLES < 2 || (DATA_WIDTH % 8) != 0) begin : g_param_check
        $error("obi_tcdm_bridge: unsupported parameter combination");
    end

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    bridge_state_e    r_state;
    bridge_state_e    w_state_nxt;
    logic             w_full;
    logic             w_accept;
    logic             w_drop_hit;
    logic             w_real_rsp;
    logic             w_syn_rsp;
    logic             w_deliver;
    logic [CNT_W-1:0] w_drop;

    // ------------------------------------------------------------------
    // Request path: attributes pass straight through; the only gating is
    // the registered full flag, so there is no path from tcdm_gnt_i to
    // tcdm_req_o.
    // ------------------------------------------------------------------
    assign w_full       = (r_cnt == MAX_CNT);
    assign tcdm_req_o   = obi_req_i & ~w_full;
    assign obi_gnt_o    = tcdm_gnt_i & tcdm_req_o;
    assign w_accept     = obi_gnt_o;

    assign tcdm_add_o   = obi_addr_i;
    assign tcdm_wen_o   = ~obi_we_i;
    assign tcdm_be_o    = obi_be_i;
    assign tcdm_wdata_o = obi_wdata_i;

    // ------------------------------------------------------------------
    // Response path. A response arriving while timed-out transactions are
    // still owed belongs to the oldest of them (responses are in order), so
    // it is swallowed. A response with nothing outstanding is ignored.
    // ------------------------------------------------------------------
    assign w_drop_hit   = tcdm_r_valid_i & (w_drop != '0);
    assign w_real_rsp   = tcdm_r_valid_i & ~w_drop_hit & (r_cnt != '0);
    assign w_deliver    = w_real_rsp | w_syn_rsp;

    assign obi_rvalid_o = w_deliver;
    assign obi_rdata_o  = w_syn_rsp ? '0 : tcdm_r_rdata_i;
    assign obi_err_o    = w_real_rsp ? tcdm_r_opc_i : w_syn_rsp;

    assign outstanding_o = r_cnt;

`ifdef OBI_TCDM_BRIDGE_TIMEOUT_EN
    logic             w_wdt_fire;
    logic [CNT_W-1:0] r_drop;
    logic [CNT_W-1:0] w_drop_nxt;

    // Armed while anything is outstanding; every forwarded real response
    // restarts the window for the next-oldest transaction.
    obi_tcdm_bridge_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(r_cnt != '0),
        .clear_i(w_real_rsp),
        .fire_o (w_wdt_fire)
    );

    // A real response in the same cycle as the timeout takes precedence.
    assign w_syn_rsp = w_wdt_fire & ~w_real_rsp;
    assign w_drop    = r_drop;

    // Drop counter next state: one more late response owed per synthetic
    // answer, one fewer per swallowed response, saturating at the window size.
    always_comb begin
        w_drop_nxt = r_drop;
        if (w_syn_rsp && !w_drop_hit) begin
            if (r_drop != MAX_CNT) begin
                w_drop_nxt = r_drop + CNT_ONE;
            end
        end else if (!w_syn_rsp && w_drop_hit) begin
            w_drop_nxt = r_drop - CNT_ONE;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_drop <= '0;
        end else begin
            r_drop <= w_drop_nxt;
        end
    end
`else
    assign w_syn_rsp = 1'b0;
    assign w_drop    = '0;
`endif

    // Outstanding count and occupancy state: next values from accepted
    // requests and responses delivered to the core.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        if (w_accept && !w_deliver) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else if (!w_accept && w_deliver) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
        end
        if (w_cnt_nxt == '0) begin
            w_state_nxt = IDLE;
        end else if (w_cnt_nxt == MAX_CNT) begin
            w_state_nxt = FULL;
        end else begin
            w_state_nxt = BUSY;
        end
    end

    // Outstanding count and occupancy state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_state <= IDLE;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    // A memory response must belong to an outstanding or timed-out request.
    a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (rst_i)
        !(tcdm_r_valid_i && (r_cnt == '0) && (w_drop == '0)))
        else $error("obi_tcdm_bridge: memory response with nothing outstanding");

    // The registered state always agrees with the count it was decoded from.
    a_state_matches_cnt : assert property (@(posedge clk_i) disable iff (rst_i)
        ((r_state == IDLE) == (r_cnt == '0)) &&
        ((r_state == FULL) == (r_cnt == MAX_CNT)))
        else $error("obi_tcdm_bridge: state does not match outstanding count");

endmodule : obi_tcdm_bridge
